pipe_skid_reg: RTL and testbench

Parametrised, back-pressure-aware pipeline register for the pipelined core. It replaces fixed, field-by-field stage registers such as EX/MEM with one generic stage carrying a control bundle and a data bundle. The stage adds a valid/ready handshake, a 2-entry skid buffer for full throughput under stall, and a synchronous flush that turns in-flight beats into bubbles with zeroed control. One instance sits between each pair of core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_skid_reg.sv | 122 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Generic back-pressure-aware pipeline stage: one main entry driving the
// outputs plus one skid entry, so the stage keeps full throughput when the
// downstream stalls. Flush kills everything held and leaves a bubble.
module pipe_skid_reg #(
    parameter int unsigned CTRL_W             = 8,
    parameter int unsigned DATA_W             = 64,
    parameter bit          ZERO_DATA_ON_FLUSH = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_v,      main_v_d;
    logic              skid_v,      skid_v_d;
    logic [CTRL_W-1:0] main_ctrl,   main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl,   skid_ctrl_d;
    logic [DATA_W-1:0] main_data,   main_data_d;
    logic [DATA_W-1:0] skid_data,   skid_data_d;
    logic [CNT_W-1:0]  stall_q,     stall_d;
    logic              in_fire;
    logic              out_fire;

    // Ready depends only on the skid register (and reset), never on out_ready.
    assign in_ready  = rst & ~skid_v;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_v & out_ready;

    assign out_valid = main_v;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = 2'(main_v) + 2'(skid_v);
    assign stall_cnt = stall_q;

    // Next-state: flush first, then the (main_v, skid_v) occupancy cases.
    always_comb begin
        main_v_d    = main_v;
        skid_v_d    = skid_v;
        main_ctrl_d = main_ctrl;
        skid_ctrl_d = skid_ctrl;
        main_data_d = main_data;
        skid_data_d = skid_data;
        stall_d     = stall_q;

        // Stall counter ignores flush; it only saturates or resets.
        if (main_v && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush) begin
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (ZERO_DATA_ON_FLUSH) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (!main_v) begin
            // Empty: an accepted beat goes straight to the output entry.
            if (in_fire) begin
                main_v_d    = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end
        end else if (!skid_v) begin
            // One beat held: replace, drain to bubble, or spill into skid.
            if (out_fire && in_fire) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else if (out_fire) begin
                main_v_d    = 1'b0;
                main_ctrl_d = '0;
            end else if (in_fire) begin
                skid_v_d    = 1'b1;
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
            end
        end else if (out_fire) begin
            // Full: the skid beat moves up; input is blocked this cycle.
            main_ctrl_d = skid_ctrl;
            main_data_d = skid_data;
            skid_v_d    = 1'b0;
            skid_ctrl_d = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            main_data <= '0;
            skid_data <= '0;
            stall_q   <= '0;
        end else begin
            main_v    <= main_v_d;
            skid_v    <= skid_v_d;
            main_ctrl <= main_ctrl_d;
            skid_ctrl <= skid_ctrl_d;
            main_data <= main_data_d;
            skid_data <= skid_data_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: accepted beats are queued, a monitor
// pops and compares every delivered beat, and directed checks cover
// occupancy, ready, flush, reset and stall counter behaviour.
module tb_pipe_skid_reg;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .CTRL_W             (CW),
        .DATA_W             (DW),
        .ZERO_DATA_ON_FLUSH (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
        return (64'(c) * 64'h0101_0101_0101_0101) ^ 64'hDEAD_0000_0000_BEEF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c);
        in_valid = v;
        in_ctrl  = c;
        in_data  = mk_data(c);
    endtask

    // Acceptance tracker: every beat taken by the stage is expected later.
    always @(negedge clk) begin
        if (rst && !flush && in_valid && in_ready)
            exp_q.push_back({in_ctrl, in_data});
    end

    // Beats still held when reset or flush hits are killed.
    always @(posedge clk) begin
        if (!rst || flush)
            exp_q.delete();
    end

    // Monitor: compare each delivered beat against the queue head.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual_ctrl=%h required=no_beat", out_ctrl);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_ctrl", 64'(out_ctrl), 64'(e.c));
                    check("sb_data", out_data, e.d);
                end
            end
            if (!out_valid)
                check("bubble_ctrl", 64'(out_ctrl), 64'd0);
            check("state_01", 64'(dut.skid_v & ~dut.main_v), 64'd0);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 8'hFF);
        tick();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_stall",     64'(stall_cnt), 64'd0);
        check("rst_occ",       64'(occupancy), 64'd0);
        tick();
        rst = 1'b1;
        drive(1'b0, 8'h00);
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);
        tick();

        // ---------------- streaming ----------------
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, CW'(i));
            @(negedge clk);
            check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_occ_le1", 64'(occupancy > 2'd1), 64'd0);
            check("stream_stall", 64'(stall_cnt), 64'd0);
            if (i == 1) begin
                check("stream_first_empty", 64'(out_valid), 64'd0);
            end else begin
                check("stream_valid", 64'(out_valid), 64'd1);
                check("stream_ctrl", 64'(out_ctrl), 64'(i - 1));
            end
            tick();
        end
        drive(1'b0, 8'h00);
        @(negedge clk);
        check("stream_last_ctrl", 64'(out_ctrl), 64'd10);
        tick();
        @(negedge clk);
        check("stream_drained", 64'(out_valid), 64'd0);
        tick();

        // ---------------- skid fill and drain ----------------
        out_ready = 1'b0;
        drive(1'b1, 8'hA1);
        @(negedge clk);
        check("skid_a_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b1, 8'hB2);
        @(negedge clk);
        check("skid_b_ready", 64'(in_ready), 64'd1);
        check("skid_b_occ",   64'(occupancy), 64'd1);
        check("skid_b_ctrl",  64'(out_ctrl), 64'hA1);
        check("skid_b_stall", 64'(stall_cnt), 64'd0);
        tick();
        drive(1'b1, 8'hC3);
        @(negedge clk);
        check("skid_full_ready", 64'(in_ready), 64'd0);
        check("skid_full_occ",   64'(occupancy), 64'd2);
        check("skid_full_stall", 64'(stall_cnt), 64'd1);
        tick();
        @(negedge clk);
        check("skid_hold_occ",   64'(occupancy), 64'd2);
        check("skid_hold_stall", 64'(stall_cnt), 64'd2);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_a", 64'(out_ctrl), 64'hA1);
        check("drain_a_ready", 64'(in_ready), 64'd0);
        check("drain_stall", 64'(stall_cnt), 64'd3);
        tick();
        @(negedge clk);
        check("drain_b", 64'(out_ctrl), 64'hB2);
        check("drain_b_ready", 64'(in_ready), 64'd1);
        check("drain_b_occ", 64'(occupancy), 64'd1);
        tick();
        drive(1'b0, 8'h00);
        @(negedge clk);
        check("drain_c", 64'(out_ctrl), 64'hC3);
        check("drain_c_occ", 64'(occupancy), 64'd1);
        tick();
        @(negedge clk);
        check("drain_empty", 64'(occupancy), 64'd0);
        check("drain_stall_hold", 64'(stall_cnt), 64'd3);
        tick();

        // ---------------- flush with full skid ----------------
        out_ready = 1'b0;
        drive(1'b1, 8'hE1);
        tick();
        drive(1'b1, 8'hE2);
        tick();
        drive(1'b1, 8'hD4);
        flush = 1'b1;
        @(negedge clk);
        check("fl_pre_occ", 64'(occupancy), 64'd2);
        check("fl_pre_stall", 64'(stall_cnt), 64'd4);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00);
        @(negedge clk);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_ctrl",  64'(out_ctrl),  64'd0);
        check("fl_occ",       64'(occupancy), 64'd0);
        check("fl_in_ready",  64'(in_ready),  64'd1);
        check("fl_data_held", out_data, mk_data(8'hE1));
        check("fl_stall",     64'(stall_cnt), 64'd5);
        tick();
        // Beat accepted during a flush into an empty stage is discarded.
        drive(1'b1, 8'hD5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00);
        @(negedge clk);
        check("fl_in_discard", 64'(out_valid), 64'd0);
        tick();

        // ---------------- simultaneous in/out fire ----------------
        out_ready = 1'b1;
        drive(1'b1, 8'hF1);
        tick();
        drive(1'b1, 8'hF2);
        @(negedge clk);
        check("sim_occ1", 64'(occupancy), 64'd1);
        check("sim_ctrl_f1", 64'(out_ctrl), 64'hF1);
        tick();
        drive(1'b0, 8'h00);
        @(negedge clk);
        check("sim_occ_stay", 64'(occupancy), 64'd1);
        check("sim_ctrl_f2", 64'(out_ctrl), 64'hF2);
        tick();

        // Flush coinciding with out_fire: the beat is delivered.
        drive(1'b1, 8'h61);
        tick();
        drive(1'b0, 8'h00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flfire_empty", 64'(out_valid), 64'd0);
        tick();

        // Reset and flush together.
        out_ready = 1'b0;
        drive(1'b1, 8'h71);
        tick();
        drive(1'b0, 8'h00);
        rst = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("rf_out_valid", 64'(out_valid), 64'd0);
        check("rf_out_ctrl",  64'(out_ctrl),  64'd0);
        check("rf_out_data",  out_data,       64'd0);
        check("rf_stall",     64'(stall_cnt), 64'd0);
        check("rf_in_ready",  64'(in_ready),  64'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rf_rel_ready", 64'(in_ready), 64'd1);
        tick();

        // ---------------- stall counter saturation ----------------
        out_ready = 1'b0;
        drive(1'b1, 8'h5A);
        tick();
        drive(1'b0, 8'h00);
        @(negedge clk);
        check("sat_start", 64'(stall_cnt), 64'd0);
        tick();
        repeat (999) tick();
        @(negedge clk);
        check("sat_1000", 64'(stall_cnt), 64'd1000);
        repeat (69000) tick();
        @(negedge clk);
        check("sat_max", 64'(stall_cnt), 64'hFFFF);
        repeat (5) tick();
        @(negedge clk);
        check("sat_hold", 64'(stall_cnt), 64'hFFFF);
        check("sat_beat", 64'(out_ctrl), 64'h5A);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("end_empty", 64'(out_valid), 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
